// File: rtl/adc0808_scan_periph_if.sv
// rtl/adc0808_scan_periph_if.sv - CPU-side register bus bundle for the ADC0808 scan peripheral
interface adc0808_scan_periph_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] d_in;
  logic [15:0] d_out;

  modport master (
    output cs, rd, wr, addr, d_in,
    input  d_out
  );

  modport slave (
    input  cs, rd, wr, addr, d_in,
    output d_out
  );
endinterface

// File: rtl/adc0808_scan_periph.sv
// rtl/adc0808_scan_periph.sv - ADC0808 four-channel scan controller with memory-mapped results
module adc0808_scan_periph #(
  parameter int ALE_CYCLES   = 2,
  parameter int START_CYCLES = 2,
  parameter int CONV_CYCLES  = 5000,
  parameter int OE_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  adc0808_scan_periph_if.slave   bus,
  output logic                   init,
  output logic                   OE_R,
  input  logic [7:0]             datain,
  output logic [2:0]             add,
  output logic                   ALE,
  output logic                   START
);

  localparam int CW = $clog2(CONV_CYCLES + ALE_CYCLES + START_CYCLES + OE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ALE,
    S_STRT,
    S_WAIT,
    S_READ,
    S_NEXT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      channel;
  logic [7:0]      r [4];
  logic            done;
  logic            start_req;
  logic            cnt_zero;
  logic            unused_d_in;

  assign start_req   = bus.cs && bus.wr && (bus.addr == 4'hA) && bus.d_in[0];
  assign cnt_zero    = (cnt == '0);
  assign unused_d_in = ^bus.d_in[15:1];

  // Register read port: one clock of latency, d_out holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.d_out <= '0;
    end else if (bus.cs && bus.rd) begin
      case (bus.addr)
        4'h0:    bus.d_out <= {8'h00, r[0]};
        4'h2:    bus.d_out <= {8'h00, r[1]};
        4'h4:    bus.d_out <= {8'h00, r[2]};
        4'h6:    bus.d_out <= {8'h00, r[3]};
        4'h8:    bus.d_out <= {15'b0, done};
        default: bus.d_out <= '0;
      endcase
    end
  end

  // Strobes are set on the transition into their state so each is a clean flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      channel <= 2'd0;
      done    <= 1'b0;
      init    <= 1'b0;
      OE_R    <= 1'b0;
      ALE     <= 1'b0;
      START   <= 1'b0;
      add     <= 3'd0;
      for (int i = 0; i < 4; i++) r[i] <= 8'h00;
    end else begin
      init <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_req) begin
            init    <= 1'b1;
            done    <= 1'b0;
            channel <= 2'd0;
            add     <= 3'd0;
            cnt     <= '0;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          ALE   <= 1'b1;
          cnt   <= CW'(ALE_CYCLES - 1);
          state <= S_ALE;
        end
        S_ALE: begin
          if (cnt_zero) begin
            ALE   <= 1'b0;
            START <= 1'b1;
            cnt   <= CW'(START_CYCLES - 1);
            state <= S_STRT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STRT: begin
          if (cnt_zero) begin
            START <= 1'b0;
            cnt   <= CW'(CONV_CYCLES - 1);
            state <= S_WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_zero) begin
            OE_R  <= 1'b1;
            cnt   <= CW'(OE_CYCLES - 1);
            state <= S_READ;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_READ: begin
          if (cnt_zero) begin
            r[channel] <= datain;
            OE_R       <= 1'b0;
            cnt        <= '0;
            state      <= S_NEXT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NEXT: begin
          cnt <= '0;
          if (channel != 2'd3) begin
            channel <= channel + 2'd1;
            add     <= {1'b0, channel + 2'd1};
            state   <= S_SETUP;
          end else begin
            done  <= 1'b1;
            add   <= 3'd0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc0808_scan_periph.sv
// tb/tb_adc0808_scan_periph.sv - directed self-checking bench for adc0808_scan_periph (CONV_CYCLES=4)
module tb_adc0808_scan_periph;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain;
  logic       init;
  logic       OE_R;
  logic       ALE;
  logic       START;
  logic [2:0] add;
  int         tests = 0;
  int         fails = 0;

  adc0808_scan_periph_if bus();

  adc0808_scan_periph #(.CONV_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .init   (init),
    .OE_R   (OE_R),
    .datain (datain),
    .add    (add),
    .ALE    (ALE),
    .START  (START)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cs   = 1'b0;
    bus.rd   = 1'b0;
    bus.wr   = 1'b0;
    bus.addr = 4'h0;
    bus.d_in = 16'h0000;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    bus.cs   = 1'b1;
    bus.rd   = 1'b1;
    bus.addr = a;
    cyc();
    v = bus.d_out;
    bus_idle();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
    bus.cs   = 1'b1;
    bus.wr   = 1'b1;
    bus.addr = a;
    bus.d_in = d;
    cyc();
    bus_idle();
  endtask

  // Expected {init, ALE, START, OE_R, add} g clocks after the accepting edge; 12 clocks per channel.
  function automatic logic [6:0] exp_pins(input int g);
    int k;
    int c;
    k = g % 12;
    c = g / 12;
    exp_pins = {(g == 0) ? 1'b1 : 1'b0,
                (k == 1 || k == 2) ? 1'b1 : 1'b0,
                (k == 3 || k == 4) ? 1'b1 : 1'b0,
                (k == 9 || k == 10) ? 1'b1 : 1'b0,
                3'(c)};
  endfunction

  task automatic test_reset();
    logic [15:0] v;
    logic [3:0]  addrs [6];
    addrs = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hC};
    rst    = 1'b0;
    datain = 8'h00;
    bus_idle();
    #12;
    tests++;
    if ({init, OE_R, ALE, START, add, bus.d_out} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0", {init, OE_R, ALE, START, add, bus.d_out});
    end
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], v);
      tests++;
      if (v !== 16'h0000) begin
        fails++;
        $display("FAIL reset_read addr=%h: got %h expected 0000", addrs[i], v);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0]  pat [4];
    logic [15:0] v;
    pat    = '{8'h11, 8'h22, 8'h33, 8'h44};
    datain = pat[0];
    bus_write(4'hA, 16'h0001);
    for (int g = 0; g < 48; g++) begin
      datain = pat[g / 12];
      tests++;
      if ({init, ALE, START, OE_R, add} !== exp_pins(g)) begin
        fails++;
        $display("FAIL scan_pins g=%0d: got %b expected %b", g, {init, ALE, START, OE_R, add}, exp_pins(g));
      end
      cyc();
    end
    tests++;
    if (add !== 3'd0) begin
      fails++;
      $display("FAIL scan_add_end: got %0d expected 0", add);
    end
    bus_read(4'h8, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL scan_done: got %h expected 0001", v);
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(2 * i), v);
      tests++;
      if (v !== {8'h00, pat[i]}) begin
        fails++;
        $display("FAIL scan_r%0d: got %h expected %h", i + 1, v, {8'h00, pat[i]});
      end
    end
    cyc();
    tests++;
    if (bus.d_out !== 16'h0044) begin
      fails++;
      $display("FAIL dout_hold: got %h expected 0044", bus.d_out);
    end
  endtask

  task automatic test_mid_scan();
    logic [7:0]  pat [4];
    logic [15:0] v;
    pat    = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    datain = pat[0];
    bus_write(4'hA, 16'h0001);
    for (int g = 0; g < 48; g++) begin
      datain = pat[g / 12];
      tests++;
      if ({init, ALE, START, OE_R, add} !== exp_pins(g)) begin
        fails++;
        $display("FAIL mid_pins g=%0d: got %b expected %b", g, {init, ALE, START, OE_R, add}, exp_pins(g));
      end
      if (g == 21) begin
        tests++;
        if (bus.d_out !== 16'h0000) begin
          fails++;
          $display("FAIL mid_done_read: got %h expected 0000", bus.d_out);
        end
      end
      bus_idle();
      if (g == 20) begin
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 4'h8;
      end
      if (g == 25) begin
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = 4'hA; bus.d_in = 16'h0001;
      end
      cyc();
    end
    bus_idle();
    bus_read(4'h8, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL mid_done_end: got %h expected 0001", v);
    end
    bus_read(4'h6, v);
    tests++;
    if (v !== 16'h008D) begin
      fails++;
      $display("FAIL mid_r4: got %h expected 008d", v);
    end
    bus_write(4'hA, 16'h0002);
    tests++;
    if (init !== 1'b0) begin
      fails++;
      $display("FAIL init_bit0_zero: got %b expected 0", init);
    end
    bus_read(4'h8, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL done_after_ignored_write: got %h expected 0001", v);
    end
  endtask

  task automatic test_rescan();
    logic [7:0]  pat [4];
    logic [15:0] v;
    pat    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    datain = pat[0];
    bus_write(4'hA, 16'h0001);
    for (int g = 0; g < 48; g++) begin
      datain = pat[g / 12];
      tests++;
      if ({init, ALE, START, OE_R, add} !== exp_pins(g)) begin
        fails++;
        $display("FAIL rescan_pins g=%0d: got %b expected %b", g, {init, ALE, START, OE_R, add}, exp_pins(g));
      end
      if (g == 1) begin
        tests++;
        if (bus.d_out !== 16'h0000) begin
          fails++;
          $display("FAIL rescan_done_cleared: got %h expected 0000", bus.d_out);
        end
      end
      bus_idle();
      if (g == 0) begin
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 4'h8;
      end
      cyc();
    end
    bus_idle();
    bus_read(4'h8, v);
    tests++;
    if (v !== 16'h0001) begin
      fails++;
      $display("FAIL rescan_done_end: got %h expected 0001", v);
    end
    bus_read(4'h2, v);
    tests++;
    if (v !== 16'h00B2) begin
      fails++;
      $display("FAIL rescan_r2: got %h expected 00b2", v);
    end
    bus_read(4'h4, v);
    tests++;
    if (v !== 16'h00C3) begin
      fails++;
      $display("FAIL rescan_r3: got %h expected 00c3", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    datain = 8'hEE;
    bus_write(4'hA, 16'h0001);
    for (int g = 0; g < 29; g++) cyc();
    tests++;
    if ({add, ALE, START, OE_R} !== {3'd2, 3'b000}) begin
      fails++;
      $display("FAIL pre_reset_wait: got %b expected 010000", {add, ALE, START, OE_R});
    end
    rst = 1'b0;
    #2;
    tests++;
    if ({init, OE_R, ALE, START, add, bus.d_out} !== 23'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {init, OE_R, ALE, START, add, bus.d_out});
    end
    #2;
    rst = 1'b1;
    cyc();
    bus_read(4'h8, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset_done: got %h expected 0000", v);
    end
    bus_read(4'h0, v);
    tests++;
    if (v !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset_r1: got %h expected 0000", v);
    end
    bus_write(4'hA, 16'h0001);
    tests++;
    if ({init, add} !== {1'b1, 3'd0}) begin
      fails++;
      $display("FAIL restart_init: got %b expected 1000", {init, add});
    end
    cyc();
    tests++;
    if ({ALE, add} !== {1'b1, 3'd0}) begin
      fails++;
      $display("FAIL restart_ale: got %b expected 1000", {ALE, add});
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_scan();
    test_rescan();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
